// File: rtl/id_scanner_pkg.sv
// Shared types and character constants for the identifier scanner.
package id_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALPHA = 2'd1,
        DIGIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        C_LETTER = 2'd0,
        C_DIGIT  = 2'd1,
        C_OTHER  = 2'd2
    } char_class_e;

    localparam logic [7:0] CH_A_UP = 8'd65;
    localparam logic [7:0] CH_Z_UP = 8'd90;
    localparam logic [7:0] CH_A_LO = 8'd97;
    localparam logic [7:0] CH_Z_LO = 8'd122;
    localparam logic [7:0] CH_0    = 8'd48;
    localparam logic [7:0] CH_9    = 8'd57;
    localparam logic [7:0] CH_US   = 8'd95;

    function automatic logic in_range(input logic [7:0] c, input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/id_scanner_char_class.sv
// Combinational character classifier: letter / digit / other.
module char_class
    import id_scanner_pkg::*;
#(
    parameter int unsigned CHAR_W = 8
) (
    input  logic [CHAR_W-1:0] char_in,
    input  logic              allow_us,
    output char_class_e       cls_c
);

    logic [7:0] low_c;
    logic       upper_set_c;

    always_comb begin
        low_c       = char_in[7:0];
        // Anything outside the 8-bit range is never part of an identifier.
        upper_set_c = |(char_in >> 8);
        cls_c       = C_OTHER;
        if (!upper_set_c) begin
            if (in_range(low_c, CH_A_UP, CH_Z_UP) || in_range(low_c, CH_A_LO, CH_Z_LO) ||
                (allow_us && (low_c == CH_US))) begin
                cls_c = C_LETTER;
            end else if (in_range(low_c, CH_0, CH_9)) begin
                cls_c = C_DIGIT;
            end
        end
    end

endmodule

// File: rtl/id_scanner.sv
// Streaming recognizer for letters+ digits{MIN_DIGITS,} tokens with run/digit
// counters, a token-complete pulse and a running token count.
module id_scanner
    import id_scanner_pkg::*;
#(
    parameter int unsigned CHAR_W     = 8,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MIN_DIGITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [CHAR_W-1:0] char_in,
    input  logic              allow_us,
    output logic              out,
    output logic [LEN_W-1:0]  len,
    output logic [LEN_W-1:0]  digit_cnt,
    output logic              token_done,
    output logic [CNT_W-1:0]  match_cnt
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] MIN_D   = LEN_W'(MIN_DIGITS);

    char_class_e      cls_c;
    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] digit_cnt_q, digit_cnt_d;
    logic             out_q, out_d;
    logic             token_done_q, token_done_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             terminate_c;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == LEN_MAX) ? v : v + LEN_W'(1);
    endfunction

    char_class #(.CHAR_W(CHAR_W)) u_char_class (
        .char_in  (char_in),
        .allow_us (allow_us),
        .cls_c    (cls_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            digit_cnt_q  <= '0;
            out_q        <= 1'b0;
            token_done_q <= 1'b0;
            match_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            digit_cnt_q  <= digit_cnt_d;
            out_q        <= out_d;
            token_done_q <= token_done_d;
            match_cnt_q  <= match_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        digit_cnt_d  = digit_cnt_q;
        out_d        = out_q;
        token_done_d = 1'b0;
        match_cnt_d  = match_cnt_q;
        terminate_c  = 1'b0;

        if (valid) begin
            case (state_q)
                IDLE: begin
                    len_d       = '0;
                    digit_cnt_d = '0;
                    if (cls_c == C_LETTER) begin
                        state_d = ALPHA;
                        len_d   = LEN_W'(1);
                    end
                end
                ALPHA: begin
                    if (cls_c == C_LETTER) begin
                        len_d = sat_inc(len_q);
                    end else if (cls_c == C_DIGIT) begin
                        state_d     = DIGIT;
                        len_d       = sat_inc(len_q);
                        digit_cnt_d = LEN_W'(1);
                    end else begin
                        state_d     = IDLE;
                        len_d       = '0;
                        digit_cnt_d = '0;
                    end
                end
                DIGIT: begin
                    if (cls_c == C_DIGIT) begin
                        len_d       = sat_inc(len_q);
                        digit_cnt_d = sat_inc(digit_cnt_q);
                    end else begin
                        // A letter both closes the token and opens a fresh run.
                        terminate_c = (digit_cnt_q >= MIN_D);
                        state_d     = (cls_c == C_LETTER) ? ALPHA : IDLE;
                        len_d       = (cls_c == C_LETTER) ? LEN_W'(1) : '0;
                        digit_cnt_d = '0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    len_d       = '0;
                    digit_cnt_d = '0;
                end
            endcase

            if (terminate_c) begin
                token_done_d = 1'b1;
                match_cnt_d  = match_cnt_q + CNT_W'(1);
            end
            out_d = (state_d == DIGIT) && (digit_cnt_d >= MIN_D);
        end
    end

    assign out        = out_q;
    assign len        = len_q;
    assign digit_cnt  = digit_cnt_q;
    assign token_done = token_done_q;
    assign match_cnt  = match_cnt_q;

endmodule

// File: tb/tb_id_scanner.sv
// Self-checking bench: three scanner configurations share one stimulus stream
// and are compared every cycle against a run-length model plus literal checks.
module tb_id_scanner;

    logic       clk = 1'b0;
    logic       reset, valid, allow_us;
    logic [7:0] ch;

    logic       o1, o2, o3, t1, t2, t3;
    logic [7:0] l1, l2, d1, d2;
    logic [2:0] l3, d3;
    logic [15:0] m1, m2, m3;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: length and trailing-digit count of the live run, unbounded.
    int md[3]   = '{1, 2, 1};
    int lmax[3] = '{255, 255, 7};
    int run_len[3], run_dig[3];
    int e_out[3], e_len[3], e_dig[3], e_done[3], e_cnt[3];

    always #5 clk = ~clk;

    id_scanner u1 (.clk(clk), .reset(reset), .valid(valid), .char_in(ch), .allow_us(allow_us),
                   .out(o1), .len(l1), .digit_cnt(d1), .token_done(t1), .match_cnt(m1));
    id_scanner #(.MIN_DIGITS(2)) u2 (.clk(clk), .reset(reset), .valid(valid), .char_in(ch),
                   .allow_us(allow_us), .out(o2), .len(l2), .digit_cnt(d2), .token_done(t2),
                   .match_cnt(m2));
    id_scanner #(.LEN_W(3)) u3 (.clk(clk), .reset(reset), .valid(valid), .char_in(ch),
                   .allow_us(allow_us), .out(o3), .len(l3), .digit_cnt(d3), .token_done(t3),
                   .match_cnt(m3));

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_tests++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input int c, input logic us);
        bit letter, digit, done;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                run_len[i] = 0; run_dig[i] = 0;
                e_out[i] = 0; e_len[i] = 0; e_dig[i] = 0; e_done[i] = 0; e_cnt[i] = 0;
            end else if (!v) begin
                e_done[i] = 0;
            end else begin
                letter = (c >= 65 && c <= 90) || (c >= 97 && c <= 122) || (us && c == 95);
                digit  = (c >= 48 && c <= 57);
                done   = 1'b0;
                if (letter) begin
                    done = (run_dig[i] >= md[i]);
                    run_len[i] = (run_dig[i] > 0) ? 1 : run_len[i] + 1;
                    run_dig[i] = 0;
                end else if (digit) begin
                    if (run_len[i] > 0) begin
                        run_len[i]++;
                        run_dig[i]++;
                    end
                end else begin
                    done = (run_dig[i] >= md[i]);
                    run_len[i] = 0;
                    run_dig[i] = 0;
                end
                e_done[i] = int'(done);
                if (done) e_cnt[i] = (e_cnt[i] + 1) % 65536;
                e_len[i] = (run_len[i] > lmax[i]) ? lmax[i] : run_len[i];
                e_dig[i] = (run_dig[i] > lmax[i]) ? lmax[i] : run_dig[i];
                e_out[i] = int'(run_dig[i] >= md[i]);
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input int c, input logic us);
        reset = r; valid = v; ch = 8'(c); allow_us = us;
        @(posedge clk);
        model_edge(r, v, c, us);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("u1.out", 32'(o1), e_out[0]);   chk("u1.len", 32'(l1), e_len[0]);
            chk("u1.dig", 32'(d1), e_dig[0]);   chk("u1.done", 32'(t1), e_done[0]);
            chk("u1.cnt", 32'(m1), e_cnt[0]);
            chk("u2.out", 32'(o2), e_out[1]);   chk("u2.len", 32'(l2), e_len[1]);
            chk("u2.dig", 32'(d2), e_dig[1]);   chk("u2.done", 32'(t2), e_done[1]);
            chk("u2.cnt", 32'(m2), e_cnt[1]);
            chk("u3.out", 32'(o3), e_out[2]);   chk("u3.len", 32'(l3), e_len[2]);
            chk("u3.dig", 32'(d3), e_dig[2]);   chk("u3.done", 32'(t3), e_done[2]);
            chk("u3.cnt", 32'(m3), e_cnt[2]);
        end
    end

    initial begin
        int s1[6]  = '{49, 97, 98, 49, 50, 37};
        int xo1[6] = '{0, 0, 0, 1, 1, 0};
        int xl1[6] = '{0, 1, 2, 3, 4, 0};
        int s3[6]  = '{95, 97, 55, 98, 51, 43};

        reset = 1'b1; valid = 1'b0; ch = 8'd0; allow_us = 1'b0;
        @(negedge clk);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk_en = 1'b1;
        chk("reset.out", 32'(o1), 0);
        chk("reset.len", 32'(l1), 0);
        chk("reset.cnt", 32'(m1), 0);

        // "1ab12%" with one trailing-digit minimum
        for (int i = 0; i < 6; i++) begin
            step(0, 1, s1[i], 0);
            chk($sformatf("tp1.out[%0d]", i), 32'(o1), xo1[i]);
            chk($sformatf("tp1.len[%0d]", i), 32'(l1), xl1[i]);
        end
        chk("tp1.done", 32'(t1), 1);
        chk("tp1.cnt", 32'(m1), 1);
        step(0, 1, 32, 0);
        chk("tp1.done_once", 32'(t1), 0);

        // "x9_" then "x99_" against the two-digit minimum
        step(1, 0, 0, 0);
        step(0, 1, 120, 0); step(0, 1, 57, 0);
        chk("tp2a.out", 32'(o2), 0);
        step(0, 1, 95, 0);
        chk("tp2a.done", 32'(t2), 0);
        chk("tp2a.cnt", 32'(m2), 0);
        step(1, 0, 0, 0);
        step(0, 1, 120, 0); step(0, 1, 57, 0); step(0, 1, 57, 0);
        chk("tp2b.out", 32'(o2), 1);
        step(0, 1, 95, 0);
        chk("tp2b.done", 32'(t2), 1);

        // "_a7b3+" with underscore as a letter
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, s3[i], 1);
            if (i == 3) begin
                chk("tp3.done_b", 32'(t1), 1);
                chk("tp3.len_b", 32'(l1), 1);
            end
        end
        chk("tp3.done_plus", 32'(t1), 1);
        chk("tp3.cnt", 32'(m1), 2);

        // "ab1", three idle cycles, '2', ' '
        step(1, 0, 0, 0);
        step(0, 1, 97, 0); step(0, 1, 98, 0); step(0, 1, 49, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 120, 0);
            chk("tp4.hold_out", 32'(o1), 1);
            chk("tp4.hold_len", 32'(l1), 3);
        end
        step(0, 1, 50, 0);
        chk("tp4.len", 32'(l1), 4);
        chk("tp4.dig", 32'(d1), 2);
        step(0, 1, 32, 0);
        chk("tp4.done", 32'(t1), 1);

        // 'a' + nine digits saturates the 3-bit counters
        step(1, 0, 0, 0);
        step(0, 1, 97, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 53, 0);
        chk("tp5.len", 32'(l3), 7);
        chk("tp5.dig", 32'(d3), 7);
        chk("tp5.out", 32'(o3), 1);
        step(0, 1, 46, 0);
        chk("tp5.done", 32'(t3), 1);

        // Reset in the middle of a live token, with a valid char present
        step(1, 0, 0, 0);
        step(0, 1, 97, 0); step(0, 1, 49, 0); step(0, 1, 98, 0); step(0, 1, 49, 0);
        chk("tp6.pre_out", 32'(o1), 1);
        chk("tp6.pre_cnt", 32'(m1), 1);
        step(1, 1, 50, 0);
        chk("tp6.out", 32'(o1), 0);
        chk("tp6.len", 32'(l1), 0);
        chk("tp6.dig", 32'(d1), 0);
        chk("tp6.done", 32'(t1), 0);
        chk("tp6.cnt", 32'(m1), 0);
        step(0, 0, 0, 0);
        chk("tp6.after_done", 32'(t1), 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_scanner.md
Name: id_scanner

Overview:
- Parametrised successor to the single-bit identifier recognizer.
- Scans a byte stream, one character per clock when `valid` is high, for tokens of the form letters+ digits{MIN_DIGITS,}.
- Reports live match status, run length, digit count, a token-complete pulse and a running token count.
- Sits behind a character source (UART/RX or testbench feeder) in the text-processing datapath.

Parameters:
- CHAR_W, 8, character width; classification uses the low 8 bits, and any set upper bit classifies as "other".
- LEN_W, 8, width of `len` and `digit_cnt`; both saturate at 2^LEN_W-1.
- CNT_W, 16, width of `match_cnt`; wraps modulo 2^CNT_W.
- MIN_DIGITS, 1, minimum trailing digits for a match; legal range 1..2^LEN_W-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- valid  in  1  `char` is sampled this edge.
- char  in  CHAR_W  input character.
- allow_us  in  1  when 1, '_' (95) counts as a letter.
- out  out  1  current stream ends in a matching token.
- len  out  LEN_W  length of the current letter+digit run, 0 when idle.
- digit_cnt  out  LEN_W  trailing digits in the current run.
- token_done  out  1  one-cycle pulse: a matching token was just terminated.
- match_cnt  out  CNT_W  number of tokens completed since reset.

Behaviour:
- Reset:
  - state=IDLE; out=0; len=0; digit_cnt=0; token_done=0; match_cnt=0.
  - Reset dominates `valid`.
  - Reset mid-token discards the token: no `token_done` pulse, no count.
- Character classes (combinational):
  - LETTER: 65..90, 97..122, or 95 when allow_us=1.
  - DIGIT: 48..57.
  - OTHER: everything else, including any char with bits above [7] set.
- States: IDLE (no live run), ALPHA (in letter run), DIGIT (in digit run preceded by ≥1 letter).
- Transitions, applied on a rising edge with valid=1:
  - IDLE + LETTER -> ALPHA; len=1; digit_cnt=0.
  - IDLE + DIGIT or OTHER -> IDLE; len=0.
  - ALPHA + LETTER -> ALPHA; len+1.
  - ALPHA + DIGIT -> DIGIT; len+1; digit_cnt=1.
  - ALPHA + OTHER -> IDLE; len=0; digit_cnt=0.
  - DIGIT + DIGIT -> DIGIT; len+1; digit_cnt+1.
  - DIGIT + LETTER -> ALPHA; len=1; digit_cnt=0. This starts a new run; "ab1c" yields "c" as the new run.
  - DIGIT + OTHER -> IDLE; len=0; digit_cnt=0.
- Token termination:
  - Applies on DIGIT->ALPHA and DIGIT->IDLE when the pre-edge digit_cnt>=MIN_DIGITS.
  - token_done=1 for exactly the following cycle.
  - match_cnt increments on the same edge.
- out: registered Moore output, (state==DIGIT && digit_cnt>=MIN_DIGITS). It is valid the cycle after the sampling edge; latency is 1 clock.
- valid=0: state, len, digit_cnt, out and match_cnt hold; token_done=0.
- Saturation:
  - len and digit_cnt stick at all-ones; the state machine keeps running.
  - A saturated digit_cnt still satisfies MIN_DIGITS.
- Simultaneous terminate + new letter (DIGIT+LETTER): the pulse and the run restart both occur on the same edge.

Decomposition:
- Package id_scanner_pkg:
  - state enum (IDLE/ALPHA/DIGIT, 2-bit encoding);
  - class enum (C_LETTER/C_DIGIT/C_OTHER);
  - char constants CH_A_UP=65, CH_Z_UP=90, CH_A_LO=97, CH_Z_LO=122, CH_0=48, CH_9=57, CH_US=95.
- One sub-module: char_class (combinational; inputs char and allow_us, output class).
- FSM, counters and output registers live in id_scanner.

Test Plan:
- MIN_DIGITS=1, valid=1, stream '1','a','b','1','2','%' (49,97,98,49,50,37):
  - out = 0,0,0,1,1,0 after each edge;
  - len = 0,1,2,3,4,0;
  - token_done pulses once after '%';
  - match_cnt=1.
- MIN_DIGITS=2, stream "x9_" with allow_us=0:
  - out stays 0; no pulse; match_cnt=0.
  - Same stream as "x99_": out=1 after the 2nd '9'; pulse after '_'.
- allow_us=1, stream "_a7b3+":
  - pulse after 'b' (DIGIT->ALPHA, first token "_a7");
  - second pulse after '+';
  - match_cnt=2;
  - len=1 right after 'b'.
- Stream "ab1" with valid dropped for 3 cycles, then '2', then ' ':
  - outputs hold (out=1, len=3) during the gap;
  - len=4, digit_cnt=2 after '2';
  - pulse after ' '.
- LEN_W=3: 'a' followed by 9 digits -> len saturates at 7, digit_cnt saturates at 7, out stays 1.
- Reset asserted while in DIGIT with out=1:
  - all outputs are 0 the next cycle; no token_done; match_cnt=0;
  - a char applied with valid=1 during reset is ignored.
